inst_word_encoder: RTL and testbench
====================================

// Module: inst_word_encoder
// PURPOSE
//  Inverse of the core's immediate decode: packs format, opcode, register fields, funct and a
//  32-bit immediate into a legal RV32I instruction word; rejects immediates that do not fit.
//  Sits between the boot/debug loader and instruction memory.
//  Encoded words are buffered in a FIFO and streamed out with a word-aligned write address.
// PARAMETERS
//  DEPTH      4             FIFO entries (power of 2, >=2)
//  ADDR_W     12            byte-address width of out_addr
//  BASE_ADDR  0             out_addr of first word after reset/flush (word-aligned)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high
//  flush      in   1   sync clear: empties FIFO, address back to BASE_ADDR, clears error
//  in_valid   in   1   request valid
//  in_ready   out  1   request can be accepted
//  fmt        in   3   0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//  opcode     in   7   placed verbatim in [6:0]
//  rd,rs1,rs2 in   5   register indices (ignored where format has none)
//  funct3     in   3   ; funct7 in 7 (R-type, and I-type shifts)
//  imm        in   32  byte immediate, two's complement
//  out_valid  out  1   FIFO head valid
//  out_ready  in   1   consumer takes head
//  out_data   out  32  encoded word ; out_addr out ADDR_W byte address of word
//  err        out  1   sticky encode error ; err_fmt out 3 fmt of failing request
// BEHAVIOUR
//  Reset: in_ready=0 during reset, then 1; out_valid=0, out_data=0, out_addr=BASE_ADDR; err=0, err_fmt=0.
//  in_ready = (count<DEPTH) && !err. Accept = in_valid && in_ready. Encode and range check are
//   combinational; word+address are written into FIFO on the accept edge.
//  Latency: accept at edge N -> out_valid high after edge N if FIFO was empty.
//  Write-address counter: +4 per accepted word, wraps modulo 2^ADDR_W; not advanced on error.
//  Pop = out_valid && out_ready; head advances. Push and pop on the same edge: count unchanged.
//   At full, in_ready=0 even if a pop is occurring that cycle.
//  Field packing: R {funct7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op};
//   I-shift (op=0010011, f3=001/101) {funct7,imm[4:0],rs1,f3,rd,op};
//   S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op};
//   U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
//  Range rules (violation = error): I/S imm[31:11] all equal; I-shift imm[31:5]==0;
//   B imm[31:12] all equal and imm[0]==0; U imm[11:0]==0; J imm[31:20] all equal and imm[0]==0;
//   fmt 6/7 always error. R ignores imm.
//  Error: on accept of a failing request nothing is pushed; err=1, err_fmt=fmt next cycle;
//   in_ready held 0; FIFO contents still drain. Cleared only by flush or reset.
//  Flush has priority over push/pop in the same cycle; the request presented is dropped.
//  Reset mid-stream discards FIFO content; no partial word is ever presented.
// CONFIGURATION
//  IMM_UJ_EN defined: fmt 4 (U) and 5 (J) encode as above.
//  IMM_UJ_EN undefined: fmt 4/5 treated as illegal (error, err_fmt=4/5); U/J packing logic absent.
// TESTING
//  I addi: fmt=1,op=0x13,rd=1,rs1=0,f3=0,imm=5 -> out_data=0x00500093, out_addr=BASE_ADDR, 1 cycle later.
//  S sw: fmt=2,op=0x23,rs1=1,rs2=2,f3=2,imm=8 -> 0x0020A423 at BASE_ADDR+4.
//  B beq: fmt=3,op=0x63,rs1=0,rs2=0,f3=0,imm=-4 -> 0xFE000EE3; imm=3 -> err=1, err_fmt=3, in_ready=0.
//  Range: fmt=1 imm=2048 -> error, no push, address unchanged; flush -> err=0, out_addr=BASE_ADDR.
//  Backpressure: out_ready=0, push DEPTH words -> in_ready=0; one pop + new request same cycle ->
//   request not accepted; order and addresses preserved.
//  U lui (IMM_UJ_EN): fmt=4,op=0x37,rd=5,imm=0x12345000 -> 0x123452B7; without macro -> err, err_fmt=4.

Source files
------------

// File: rtl/inst_word_encoder.sv
// RV32I instruction-word encoder with range checking, a small output FIFO and a word-aligned write-address counter.
// Optional feature: define IMM_UJ_EN to enable U/J formats (otherwise fmt 4/5 are rejected as illegal).
module inst_word_encoder #(
  parameter int                  DEPTH     = 4,
  parameter int                  ADDR_W    = 12,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [2:0]        err_fmt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic [31:0]       enc_word;
  logic              enc_bad;
  logic              is_shift;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              err_q, err_d;
  logic [2:0]        err_fmt_q, err_fmt_d;
  logic              init_q;

  logic [31:0]       data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];

  logic accept, push, pop, err_set;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    enc_word = '0;
    enc_bad  = 1'b0;
    is_shift = (opcode == 7'b0010011) && ((funct3 == 3'b001) || (funct3 == 3'b101));
    case (fmt_e'(fmt))
      FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        if (is_shift) begin
          enc_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
          enc_bad  = |imm[31:5];
        end else begin
          enc_word = {imm[11:0], rs1, funct3, rd, opcode};
          enc_bad  = !((&imm[31:11]) || !(|imm[31:11]));
        end
      end
      FMT_S: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_bad  = !((&imm[31:11]) || !(|imm[31:11]));
      end
      FMT_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_bad  = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      end
`ifdef IMM_UJ_EN
      FMT_U: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_bad  = |imm[11:0];
      end
      FMT_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_bad  = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      end
`endif
      default: enc_bad = 1'b1;
    endcase
  end

  assign in_ready  = init_q && (count_q < CNT_W'(DEPTH)) && !err_q;
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && !enc_bad;
  assign err_set   = accept && enc_bad;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    wr_addr_d = wr_addr_q;
    err_d     = err_q;
    err_fmt_d = err_fmt_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      wr_addr_d = BASE_ADDR;
      err_d     = 1'b0;
      err_fmt_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        wr_addr_d = wr_addr_q + ADDR_W'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
      if (err_set) begin
        err_d     = 1'b1;
        err_fmt_d = fmt;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_addr_q <= BASE_ADDR;
      err_q     <= 1'b0;
      err_fmt_q <= '0;
      init_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_addr_q <= wr_addr_d;
      err_q     <= err_d;
      err_fmt_q <= err_fmt_d;
      init_q    <= 1'b1;
    end
  end

  // NOTE: storage is not reset; count_q gates visibility, so stale entries are never presented.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      data_mem[wr_ptr_q] <= enc_word;
      addr_mem[wr_ptr_q] <= wr_addr_q;
    end
  end

  // When empty, out_addr shows where the next word will land.
  assign out_data = out_valid ? data_mem[rd_ptr_q] : '0;
  assign out_addr = out_valid ? addr_mem[rd_ptr_q] : wr_addr_q;
  assign err      = err_q;
  assign err_fmt  = err_fmt_q;

endmodule

// File: tb/tb_inst_word_encoder.sv
// Directed testbench for inst_word_encoder (DEPTH=4, ADDR_W=12, BASE_ADDR=0).
module tb_inst_word_encoder;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [11:0] out_addr;
  logic        err;
  logic [2:0]  err_fmt;

  int n_checks = 0;
  int n_errors = 0;

  inst_word_encoder #(.DEPTH(4), .ADDR_W(12), .BASE_ADDR(12'h000)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr),
    .err(err), .err_fmt(err_fmt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im);
    set_req(f, op, d, s1, s2, f3, f7, im);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0);

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'h0);
    check("rst_out_addr",  32'(out_addr),  32'h0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_err_fmt",   32'(err_fmt),   32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // I addi x1,x0,5 ; S sw x2,8(x1)
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5);
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_data",  out_data,       32'h00500093);
    check("addi_addr",  32'(out_addr),  32'h000);
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8);
    check("fifo_head_kept", out_data, 32'h00500093);
    pop_one();
    check("sw_data", out_data,      32'h0020A423);
    check("sw_addr", 32'(out_addr), 32'h004);
    pop_one();
    check("drained_valid", 32'(out_valid), 32'd0);

    // B beq, legal then odd immediate
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC);
    check("beq_data", out_data,      32'hFE000EE3);
    check("beq_addr", 32'(out_addr), 32'h008);
    pop_one();
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3);
    check("beq_odd_err",      32'(err),       32'd1);
    check("beq_odd_err_fmt",  32'(err_fmt),   32'd3);
    check("beq_odd_in_ready", 32'(in_ready),  32'd0);
    check("beq_odd_no_push",  32'(out_valid), 32'd0);
    check("beq_odd_addr",     32'(out_addr),  32'h00C);
    do_flush();
    check("flush_err",      32'(err),      32'd0);
    check("flush_addr",     32'(out_addr), 32'h000);
    check("flush_in_ready", 32'(in_ready), 32'd1);

    // I immediate out of range
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048);
    check("i_range_err",     32'(err),       32'd1);
    check("i_range_err_fmt", 32'(err_fmt),   32'd1);
    check("i_range_no_push", 32'(out_valid), 32'd0);
    check("i_range_addr",    32'(out_addr),  32'h000);
    do_flush();

    // Backpressure: fill four entries, then pop while offering a fifth
    for (int i = 0; i < 4; i++)
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'(i));
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head",     out_data,      32'h00000093);
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd9);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("after_pop_in_ready", 32'(in_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("bp_data%0d", i), out_data,      (32'(i) << 20) | 32'h93);
      check($sformatf("bp_addr%0d", i), 32'(out_addr), 32'(i) * 4);
      pop_one();
    end
    check("bp_empty",     32'(out_valid), 32'd0);
    check("bp_next_addr", 32'(out_addr),  32'h010);

    // I-shift: srai-style encoding slli x2,x3,3 with funct7=0x20
    send(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd1, 7'h20, 32'd3);
    check("shift_data", out_data,      32'h40319113);
    check("shift_addr", 32'(out_addr), 32'h010);
    pop_one();
    send(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd5, 7'h00, 32'd32);
    check("shift_range_err", 32'(err),     32'd1);
    check("shift_range_fmt", 32'(err_fmt), 32'd1);
    do_flush();

    // R add x3,x1,x2 (imm ignored)
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEADBEEF);
    check("r_add_data", out_data, 32'h002081B3);
    check("r_add_err",  32'(err), 32'd0);
    pop_one();

    // U lui x5,0x12345
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000);
`ifdef IMM_UJ_EN
    check("lui_data", out_data,      32'h123452B7);
    check("lui_addr", 32'(out_addr), 32'h004);
    check("lui_err",  32'(err),      32'd0);
`else
    check("lui_err",     32'(err),       32'd1);
    check("lui_err_fmt", 32'(err_fmt),   32'd4);
    check("lui_no_push", 32'(out_valid), 32'd0);
`endif
    do_flush();

    // Illegal format
    send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);
    check("fmt6_err",     32'(err),     32'd1);
    check("fmt6_err_fmt", 32'(err_fmt), 32'd6);
    do_flush();

    // Reset mid-stream discards buffered word
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_valid",    32'(out_valid), 32'd0);
    check("mid_reset_addr",     32'(out_addr),  32'h000);
    check("mid_reset_in_ready", 32'(in_ready),  32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("after_reset_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
